// File: rtl/microcode_pkg.sv
// Microcode word layout shared by the front-end pipeline stages.
// Each stage pulls its control fields out through the extractors below.
package microcode;

    localparam int WIDTH = 16;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        AND    = 4'd2,
        OR     = 4'd3,
        XOR    = 4'd4,
        SLT    = 4'd5,
        SLTU   = 4'd6,
        SLL    = 4'd7,
        SRL    = 4'd8,
        SRA    = 4'd9,
        PASS_A = 4'd10,
        PASS_B = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_e;

    // Stage-0 operand source selects occupy the low nibble.
    function automatic logic [1:0] mcs0_src_a_sel(input logic [WIDTH-1:0] mc);
        return mc[1:0];
    endfunction

    function automatic logic [1:0] mcs0_src_b_sel(input logic [WIDTH-1:0] mc);
        return mc[3:2];
    endfunction

    function automatic alu_op_e mcs1_alu_op(input logic [WIDTH-1:0] mc);
        return alu_op_e'(mc[7:4]);
    endfunction

endpackage

// File: rtl/alu_stage_shift_step.sv
// One step of the iterative shifter: moves acc by 0..4 bit positions.
module shift_step
    import microcode::*;
(
    input  logic [31:0]  acc,
    input  shift_kind_e  kind,
    input  logic [2:0]   amt,
    output logic [31:0]  result
);

    always_comb begin
        result = acc;
        case (kind)
            SK_SLL:  result = acc << amt;
            SK_SRL:  result = acc >> amt;
            SK_SRA:  result = 32'($signed(acc) >>> amt);
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/alu_stage.sv
// Execute stage: single-cycle arithmetic/logic/compare plus a multi-cycle
// shifter that stalls the rest of the pipeline while it iterates.
module alu_stage
    import microcode::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_enable,
    input  logic [WIDTH-1:0]       microcode_s1,
    input  logic [31:0]            pre_alu_a,
    input  logic [31:0]            pre_alu_b,
    output logic [31:0]            alu_result,
    output logic                   flag_eq,
    output logic                   flag_lt,
    output logic                   flag_ltu,
    output logic                   stall
);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e       state;
    logic [31:0]  acc;
    logic [4:0]   rem;
    shift_kind_e  kind;

    alu_op_e      op;
    logic [4:0]   shamt;
    logic         is_shift;
    logic         cmp_lt;
    logic         cmp_ltu;
    logic [31:0]  single_result;
    shift_kind_e  op_kind;
    logic [2:0]   step;
    logic [31:0]  shifted;
    logic         unused_bits;

    assign op          = mcs1_alu_op(microcode_s1);
    assign shamt       = pre_alu_b[4:0];
    assign is_shift    = (op == SLL) || (op == SRL) || (op == SRA);
    assign cmp_lt      = $signed(pre_alu_a) < $signed(pre_alu_b);
    assign cmp_ltu     = pre_alu_a < pre_alu_b;
    assign step        = (rem > 5'd4) ? 3'd4 : rem[2:0];
    assign unused_bits = ^{microcode_s1[3:0], microcode_s1[WIDTH-1:8], pre_alu_b[31:5]};

    // Shift ops only reach this path with a zero amount, so they pass A through.
    always_comb begin
        single_result = '0;
        case (op)
            ADD:            single_result = pre_alu_a + pre_alu_b;
            SUB:            single_result = pre_alu_a - pre_alu_b;
            AND:            single_result = pre_alu_a & pre_alu_b;
            OR:             single_result = pre_alu_a | pre_alu_b;
            XOR:            single_result = pre_alu_a ^ pre_alu_b;
            SLT:            single_result = {31'b0, cmp_lt};
            SLTU:           single_result = {31'b0, cmp_ltu};
            SLL, SRL, SRA:  single_result = pre_alu_a;
            PASS_A:         single_result = pre_alu_a;
            PASS_B:         single_result = pre_alu_b;
            default:        single_result = '0;
        endcase
    end

    always_comb begin
        op_kind = SK_SLL;
        case (op)
            SRL:     op_kind = SK_SRL;
            SRA:     op_kind = SK_SRA;
            default: op_kind = SK_SLL;
        endcase
    end

    shift_step u_shift_step (
        .acc    (acc),
        .kind   (kind),
        .amt    (step),
        .result (shifted)
    );

    // Drops in the last shift cycle so the pipeline advances as the result lands.
    assign stall = ((state == IDLE) && clk_enable && is_shift && (shamt != 5'd0))
                 || ((state == SHIFT) && (rem > 5'd4));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            rem        <= '0;
            kind       <= SK_SLL;
            alu_result <= '0;
            flag_eq    <= 1'b0;
            flag_lt    <= 1'b0;
            flag_ltu   <= 1'b0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    flag_eq  <= pre_alu_a == pre_alu_b;
                    flag_lt  <= cmp_lt;
                    flag_ltu <= cmp_ltu;
                    if (is_shift && (shamt != 5'd0)) begin
                        acc   <= pre_alu_a;
                        rem   <= shamt;
                        kind  <= op_kind;
                        state <= SHIFT;
                    end else begin
                        alu_result <= single_result;
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    rem <= rem - {2'b00, step};
                    if (rem <= 5'd4) begin
                        alu_result <= shifted;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Directed and randomized checks of alu_stage against a plain-arithmetic reference.
module tb_alu_stage;
    import microcode::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_enable;
    logic [WIDTH-1:0]  microcode_s1;
    logic [31:0]       pre_alu_a;
    logic [31:0]       pre_alu_b;
    logic [31:0]       alu_result;
    logic              flag_eq;
    logic              flag_lt;
    logic              flag_ltu;
    logic              stall;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    alu_stage dut (
        .clk          (clk),
        .rst          (rst),
        .clk_enable   (clk_enable),
        .microcode_s1 (microcode_s1),
        .pre_alu_a    (pre_alu_a),
        .pre_alu_b    (pre_alu_b),
        .alu_result   (alu_result),
        .flag_eq      (flag_eq),
        .flag_lt      (flag_lt),
        .flag_ltu     (flag_ltu),
        .stall        (stall)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refResult(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:    return (a < b) ? 32'd1 : 32'd0;
            SLL:     return a << n;
            SRL:     return a >> n;
            SRA:     return 32'($signed(a) >>> n);
            PASS_A:  return a;
            PASS_B:  return b;
            default: return 32'd0;
        endcase
    endfunction

    // Presents one op, walks it to completion and checks stall, result and flags.
    // With insert_idle set, a disabled cycle precedes every shift step.
    task automatic applyStimulus(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 input bit insert_idle, input string tag);
        int          n;
        bit          shift_op;
        int          cycles;
        logic [31:0] exp_res;
        n        = int'(b[4:0]);
        shift_op = (op == SLL) || (op == SRL) || (op == SRA);
        cycles   = (shift_op && n != 0) ? (n + 3) / 4 : 0;
        exp_res  = refResult(op, a, b);

        microcode_s1      = '0;
        microcode_s1[7:4] = op;
        pre_alu_a         = a;
        pre_alu_b         = b;
        clk_enable        = 1'b1;
        #1;
        checkOutput({tag, " stall_accept"}, 32'(stall), 32'(cycles > 0));
        tick();
        for (int k = cycles; k >= 1; k--) begin
            if (insert_idle) begin
                clk_enable = 1'b0;
                #1;
                checkOutput({tag, " stall_frozen"}, 32'(stall), 32'(k > 1));
                tick();
                checkOutput({tag, " result_frozen"}, alu_result, last_result);
                clk_enable = 1'b1;
            end
            #1;
            checkOutput({tag, " stall_shift"}, 32'(stall), 32'(k > 1));
            checkOutput({tag, " result_held"}, alu_result, last_result);
            tick();
        end
        last_result = exp_res;
        checkOutput({tag, " result"}, alu_result, exp_res);
        checkOutput({tag, " flag_eq"}, 32'(flag_eq), 32'(a == b));
        checkOutput({tag, " flag_lt"}, 32'(flag_lt), 32'($signed(a) < $signed(b)));
        checkOutput({tag, " flag_ltu"}, 32'(flag_ltu), 32'(a < b));
    endtask

    initial begin
        rst          = 1'b1;
        clk_enable   = 1'b1;
        microcode_s1 = '0;
        pre_alu_a    = '0;
        pre_alu_b    = '0;
        last_result  = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset result", alu_result, 32'd0);
        checkOutput("reset flag_eq", 32'(flag_eq), 32'd0);
        checkOutput("reset flag_lt", 32'(flag_lt), 32'd0);
        checkOutput("reset flag_ltu", 32'(flag_ltu), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);

        applyStimulus(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, "add_wrap");
        applyStimulus(SUB, 32'd5, 32'd7, 1'b0, "sub_neg");
        applyStimulus(SLTU, 32'd5, 32'd7, 1'b0, "sltu");
        applyStimulus(SRA, 32'h8000_0000, 32'd31, 1'b0, "sra_31");
        applyStimulus(SLL, 32'd1, 32'h25, 1'b1, "sll_5_gated");
        applyStimulus(SRL, 32'hDEAD_BEEF, 32'h20, 1'b0, "srl_zero");

        // Disabled accept cycle must leave every output untouched.
        microcode_s1      = '0;
        microcode_s1[7:4] = ADD;
        pre_alu_a         = 32'd1;
        pre_alu_b         = 32'd2;
        clk_enable        = 1'b0;
        tick();
        checkOutput("disabled_accept result", alu_result, last_result);
        clk_enable = 1'b1;

        applyStimulus(alu_op_e'(4'd13), 32'h1234_5678, 32'h0000_0010, 1'b0, "unused_op");
        applyStimulus(PASS_B, 32'h0, 32'hCAFE_F00D, 1'b0, "pass_b");

        // Abort a shift with 20 positions still to go.
        microcode_s1      = '0;
        microcode_s1[7:4] = SLL;
        pre_alu_a         = 32'h0000_0003;
        pre_alu_b         = 32'd24;
        clk_enable        = 1'b1;
        tick();
        tick();
        checkOutput("abort stall_before", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst               = 1'b0;
        microcode_s1[7:4] = ADD;
        #1;
        checkOutput("abort stall", 32'(stall), 32'd0);
        checkOutput("abort result", alu_result, 32'd0);
        checkOutput("abort flag_ltu", 32'(flag_ltu), 32'd0);
        last_result = '0;
        applyStimulus(XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, "after_abort");

        for (int i = 0; i < 60; i++) begin
            alu_op_e     rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = alu_op_e'(4'($urandom_range(0, 15)));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            applyStimulus(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
